// File: rtl/tb_dina_seq_ctrl.sv
// tb_dina_seq_ctrl: issues CB port-A reads for one transfer command and drives the TB port-A mapper
// with selector/row/half-select aligned to CB read data, plus TB write enable/address one cycle later.
module tb_dina_seq_ctrl #(
  parameter int SEQ_CNT_DW = 10,
  parameter int TB_DINA_SEL_DW = 5,
  parameter int CB_AW = 10,
  parameter int TB_AW = 10,
  parameter int CB_RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_mode,
  input  logic [1:0]                cmd_dir,
  input  logic                      cmd_l_k_0,
  input  logic [SEQ_CNT_DW-1:0]     cmd_len,
  input  logic [CB_AW-1:0]          cmd_cb_base,
  input  logic [TB_AW-1:0]          cmd_tb_base,
  input  logic                      cmd_tb_dec,
  output logic                      cb_ena,
  output logic [CB_AW-1:0]          cb_addra,
  output logic [TB_DINA_SEL_DW-1:0] TB_dina_sel,
  output logic [SEQ_CNT_DW-1:0]     seq_cnt_out,
  output logic                      l_k_0,
  output logic                      tb_wea,
  output logic [TB_AW-1:0]          tb_addra,
  output logic                      done,
  output logic                      cmd_err
);
  localparam logic [2:0] CB_COPY = 3'b100;
  localparam logic [2:0] NL_UPD = 3'b111;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  state_t state;
  logic [SEQ_CNT_DW-1:0] len;
  logic [CB_AW-1:0] cb_base;
  logic [TB_AW-1:0] tb_base;
  logic tb_dec;
  // Stage 0 holds the row whose CB read is being issued; s0_k doubles as the row counter.
  logic s0_vld, s0_lk;
  logic [TB_DINA_SEL_DW-1:0] s0_sel;
  logic [SEQ_CNT_DW-1:0] s0_k;
  logic [TB_AW-1:0] s0_tb;
  logic [CB_RD_LAT-1:0] p_vld, p_lk;
  logic [TB_DINA_SEL_DW-1:0] p_sel [CB_RD_LAT];
  logic [SEQ_CNT_DW-1:0] p_k [CB_RD_LAT];
  logic [TB_AW-1:0] p_tb [CB_RD_LAT];
  logic legal;
  assign legal = cmd_mode == CB_COPY || cmd_mode == NL_UPD;
  assign TB_dina_sel = p_sel[CB_RD_LAT-1];
  assign seq_cnt_out = p_k[CB_RD_LAT-1];
  assign l_k_0 = p_lk[CB_RD_LAT-1];
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      len <= '0;
      cb_base <= '0;
      tb_base <= '0;
      tb_dec <= 1'b0;
      s0_vld <= 1'b0;
      s0_lk <= 1'b0;
      s0_sel <= '0;
      s0_k <= '0;
      s0_tb <= '0;
      cb_ena <= 1'b0;
      cb_addra <= '0;
      p_vld <= '0;
      p_lk <= '0;
      for (int i = 0; i < CB_RD_LAT; i++) begin
        p_sel[i] <= '0;
        p_k[i] <= '0;
        p_tb[i] <= '0;
      end
      tb_wea <= 1'b0;
      tb_addra <= '0;
      done <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      for (int i = CB_RD_LAT - 1; i > 0; i--) begin
        p_vld[i] <= p_vld[i-1];
        p_lk[i] <= p_lk[i-1];
        p_sel[i] <= p_sel[i-1];
        p_k[i] <= p_k[i-1];
        p_tb[i] <= p_tb[i-1];
      end
      p_vld[0] <= s0_vld;
      p_lk[0] <= s0_lk;
      p_sel[0] <= s0_sel;
      p_k[0] <= s0_k;
      p_tb[0] <= s0_tb;
      tb_wea <= p_vld[CB_RD_LAT-1];
      tb_addra <= p_tb[CB_RD_LAT-1];
      done <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            len <= cmd_len;
            cb_base <= cmd_cb_base;
            tb_base <= cmd_tb_base;
            tb_dec <= cmd_tb_dec;
            if (!legal || cmd_len == '0) begin
              state <= FIN;
              done <= 1'b1;
              cmd_err <= !legal;
            end else begin
              state <= ISSUE;
              s0_vld <= 1'b1;
              s0_sel <= TB_DINA_SEL_DW'({cmd_mode, cmd_dir});
              s0_k <= SEQ_CNT_DW'(1);
              s0_lk <= cmd_l_k_0;
              s0_tb <= cmd_tb_base;
              cb_ena <= cmd_mode == CB_COPY;
              cb_addra <= cmd_mode == CB_COPY ? cmd_cb_base : '0;
            end
          end else
            cmd_ready <= 1'b1;
        end
        ISSUE: begin
          if (s0_k == len) begin
            state <= DRAIN;
            s0_vld <= 1'b0;
            s0_lk <= 1'b0;
            s0_sel <= '0;
            s0_k <= '0;
            s0_tb <= '0;
            cb_ena <= 1'b0;
            cb_addra <= '0;
          end else begin
            s0_k <= s0_k + 1'b1;
            s0_tb <= tb_dec ? tb_base - TB_AW'(s0_k) : tb_base + TB_AW'(s0_k);
            cb_addra <= cb_ena ? cb_base + CB_AW'(s0_k) : '0;
          end
        end
        DRAIN: begin
          if (p_vld == '0) begin
            state <= FIN;
            done <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tb_dina_seq_ctrl.sv
// tb_tb_dina_seq_ctrl: directed bench for tb_dina_seq_ctrl at CB_RD_LAT = 1 and 3,
// comparing a per-cycle snapshot of all outputs against hand-derived timing expectations.
module tb_tb_dina_seq_ctrl;
  logic clk = 1'b0, sys_rst = 1'b0, v1 = 1'b0, v3 = 1'b0;
  logic [2:0] mode = '0;
  logic [1:0] dir = '0;
  logic lk = 1'b0, dec = 1'b0;
  logic [9:0] len = '0, cbb = '0, tbb = '0;
  logic rdy1, ena1, lko1, wea1, done1, err1, rdy3, ena3, lko3, wea3, done3, err3;
  logic [9:0] cba1, seq1, tba1, cba3, seq3, tba3;
  logic [4:0] sel1, sel3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  tb_dina_seq_ctrl #(.CB_RD_LAT(1)) u1 (
    .clk(clk), .sys_rst(sys_rst), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_mode(mode), .cmd_dir(dir),
    .cmd_l_k_0(lk), .cmd_len(len), .cmd_cb_base(cbb), .cmd_tb_base(tbb), .cmd_tb_dec(dec),
    .cb_ena(ena1), .cb_addra(cba1), .TB_dina_sel(sel1), .seq_cnt_out(seq1), .l_k_0(lko1),
    .tb_wea(wea1), .tb_addra(tba1), .done(done1), .cmd_err(err1)
  );
  tb_dina_seq_ctrl #(.CB_RD_LAT(3)) u3 (
    .clk(clk), .sys_rst(sys_rst), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_mode(mode), .cmd_dir(dir),
    .cmd_l_k_0(lk), .cmd_len(len), .cmd_cb_base(cbb), .cmd_tb_base(tbb), .cmd_tb_dec(dec),
    .cb_ena(ena3), .cb_addra(cba3), .TB_dina_sel(sel3), .seq_cnt_out(seq3), .l_k_0(lko3),
    .tb_wea(wea3), .tb_addra(tba3), .done(done3), .cmd_err(err3)
  );
  typedef struct packed {
    logic rdy, ena;
    logic [9:0] cba;
    logic [4:0] sel;
    logic [9:0] seq;
    logic lk, wea;
    logic [9:0] tba;
    logic done, err;
  } obs_t;
  obs_t cap [32];
  // Addresses are only meaningful alongside their enables, so they are masked otherwise.
  function automatic obs_t get_obs(bit b);
    obs_t o;
    o.rdy = b ? rdy3 : rdy1;
    o.ena = b ? ena3 : ena1;
    o.cba = o.ena ? (b ? cba3 : cba1) : '0;
    o.sel = b ? sel3 : sel1;
    o.seq = b ? seq3 : seq1;
    o.lk = b ? lko3 : lko1;
    o.wea = b ? wea3 : wea1;
    o.tba = o.wea ? (b ? tba3 : tba1) : '0;
    o.done = b ? done3 : done1;
    o.err = b ? err3 : err1;
    return o;
  endfunction
  // Expected outputs j cycles after accept: row r reads CB at j=r, reaches the mapper at j=r+lat,
  // is written to TB at j=r+lat+1; done follows the last write, ready returns the cycle after done.
  function automatic obs_t model(int j, int lat, int m, int d, int l, int n, int cb, int tb, int dc);
    obs_t e;
    int r;
    e = '0;
    if (!(m == 4 || m == 7) || n == 0) begin
      e.done = (j == 1);
      e.err = (j == 1) && !(m == 4 || m == 7);
      e.rdy = (j >= 2);
      return e;
    end
    if (m == 4 && j >= 1 && j <= n) begin
      e.ena = 1'b1;
      e.cba = 10'(cb + j - 1);
    end
    r = j - lat;
    if (r >= 1 && r <= n) begin
      e.sel = {m[2:0], d[1:0]};
      e.seq = 10'(r);
      e.lk = l[0];
    end
    r = j - lat - 1;
    if (r >= 1 && r <= n) begin
      e.wea = 1'b1;
      e.tba = 10'(dc != 0 ? tb - (r - 1) : tb + (r - 1));
    end
    e.done = (j == n + lat + 2);
    e.rdy = (j >= n + lat + 3);
    return e;
  endfunction
  task automatic send(input bit b, input int m, d, l, n, cb, tb, dc);
    int t = 0;
    @(negedge clk);
    mode = 3'(m); dir = 2'(d); lk = l[0]; len = 10'(n); cbb = 10'(cb); tbb = 10'(tb); dec = dc[0];
    while (!(b ? rdy3 : rdy1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t == 20) begin
      errors++;
      $display("FAIL send_ready u%0d got cmd_ready=0 expected 1", b ? 3 : 1);
    end
    if (b) v3 = 1'b1;
    else v1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0;
    v3 = 1'b0;
  endtask
  task automatic capture(input bit b, input int n);
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      cap[j] = get_obs(b);
    end
  endtask
  task automatic test_reset;
    obs_t e;
    e = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (get_obs(0) !== e) begin errors++; $display("FAIL reset_u1 got %h expected %h", get_obs(0), e); end
    checks++;
    if (get_obs(1) !== e) begin errors++; $display("FAIL reset_u3 got %h expected %h", get_obs(1), e); end
    sys_rst = 1'b1;
    @(negedge clk);
    e.rdy = 1'b1;
    checks++;
    if (get_obs(0) !== e) begin errors++; $display("FAIL release_u1 got %h expected %h", get_obs(0), e); end
    checks++;
    if (get_obs(1) !== e) begin errors++; $display("FAIL release_u3 got %h expected %h", get_obs(1), e); end
  endtask
  task automatic test_cb_copy_pos;
    obs_t e;
    send(0, 4, 1, 0, 4, 8, 0, 0);
    capture(0, 10);
    for (int j = 1; j <= 10; j++) begin
      e = model(j, 1, 4, 1, 0, 4, 8, 0, 0);
      checks++;
      if (cap[j] !== e) begin errors++; $display("FAIL cb_copy_pos j=%0d got %h expected %h", j, cap[j], e); end
    end
  endtask
  task automatic test_new_dec;
    obs_t e;
    for (int l = 0; l < 2; l++) begin
      send(0, 4, 3, l, 2, 20, 5, 1);
      capture(0, 8);
      for (int j = 1; j <= 8; j++) begin
        e = model(j, 1, 4, 3, l, 2, 20, 5, 1);
        checks++;
        if (cap[j] !== e) begin errors++; $display("FAIL new_dec lk=%0d j=%0d got %h expected %h", l, j, cap[j], e); end
      end
    end
  endtask
  task automatic test_nl_upd;
    obs_t e;
    send(0, 7, 0, 0, 2, 0, 0, 0);
    capture(0, 8);
    for (int j = 1; j <= 8; j++) begin
      e = model(j, 1, 7, 0, 0, 2, 0, 0, 0);
      checks++;
      if (cap[j] !== e) begin errors++; $display("FAIL nl_upd j=%0d got %h expected %h", j, cap[j], e); end
    end
  endtask
  task automatic test_illegal_and_len0;
    obs_t e;
    send(0, 2, 1, 0, 3, 8, 0, 0);
    capture(0, 6);
    for (int j = 1; j <= 6; j++) begin
      e = model(j, 1, 2, 1, 0, 3, 8, 0, 0);
      checks++;
      if (cap[j] !== e) begin errors++; $display("FAIL illegal j=%0d got %h expected %h", j, cap[j], e); end
    end
    send(0, 4, 1, 0, 0, 8, 0, 0);
    capture(0, 6);
    for (int j = 1; j <= 6; j++) begin
      e = model(j, 1, 4, 1, 0, 0, 8, 0, 0);
      checks++;
      if (cap[j] !== e) begin errors++; $display("FAIL len0 j=%0d got %h expected %h", j, cap[j], e); end
    end
  endtask
  task automatic test_wrap;
    obs_t e;
    send(0, 4, 1, 1, 2, 1023, 1023, 0);
    capture(0, 8);
    for (int j = 1; j <= 8; j++) begin
      e = model(j, 1, 4, 1, 1, 2, 1023, 1023, 0);
      checks++;
      if (cap[j] !== e) begin errors++; $display("FAIL wrap j=%0d got %h expected %h", j, cap[j], e); end
    end
  endtask
  task automatic test_long;
    int wc = 0, dj = 0;
    logic [9:0] last = '0;
    send(0, 7, 1, 0, 1023, 0, 0, 0);
    for (int j = 1; j <= 1040; j++) begin
      @(negedge clk);
      if (wea1) wc++;
      if (sel1 != '0) last = seq1;
      if (done1 && dj == 0) dj = j;
    end
    checks++;
    if (wc != 1023) begin errors++; $display("FAIL long_wea_count got %0d expected 1023", wc); end
    checks++;
    if (dj != 1026) begin errors++; $display("FAIL long_done_cycle got %0d expected 1026", dj); end
    checks++;
    if (last != 10'd1023) begin errors++; $display("FAIL long_last_seq got %0d expected 1023", last); end
  endtask
  task automatic test_reset_mid;
    obs_t e;
    e = '0;
    send(0, 4, 1, 1, 8, 100, 200, 0);
    repeat (3) @(negedge clk);
    #2 sys_rst = 1'b0;
    #1;
    checks++;
    if (get_obs(0) !== e) begin errors++; $display("FAIL reset_mid got %h expected %h", get_obs(0), e); end
    checks++;
    if ({cba1, tba1} !== 20'd0) begin errors++; $display("FAIL reset_mid_addr got %h expected 0", {cba1, tba1}); end
    @(negedge clk);
    sys_rst = 1'b1;
    capture(0, 6);
    e.rdy = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      checks++;
      if (cap[j] !== e) begin errors++; $display("FAIL post_reset j=%0d got %h expected %h", j, cap[j], e); end
    end
  endtask
  task automatic test_lat3_back_to_back;
    obs_t e;
    send(1, 4, 1, 1, 5, 8, 0, 0);
    capture(1, 12);
    for (int j = 1; j <= 12; j++) begin
      e = model(j, 3, 4, 1, 1, 5, 8, 0, 0);
      checks++;
      if (cap[j] !== e) begin errors++; $display("FAIL lat3 j=%0d got %h expected %h", j, cap[j], e); end
    end
    send(1, 7, 2, 0, 3, 0, 10, 1);
    capture(1, 11);
    for (int j = 1; j <= 11; j++) begin
      e = model(j, 3, 7, 2, 0, 3, 0, 10, 1);
      checks++;
      if (cap[j] !== e) begin errors++; $display("FAIL lat3_b2b j=%0d got %h expected %h", j, cap[j], e); end
    end
  endtask
  initial begin
    test_reset();
    test_cb_copy_pos();
    test_new_dec();
    test_nl_upd();
    test_illegal_and_len0();
    test_wrap();
    test_long();
    test_reset_mid();
    test_lat3_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
